// File: rtl/pipelined_instruction_decoder_if.sv
// rtl/pipelined_instruction_decoder_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface pipelined_instruction_decoder_if #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 64
);
    // Fetch (IF/ID) side
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;

    // Execute (ID/EX) side
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic              out_reg2loc;
    logic              out_alusrc;
    logic              out_memtoreg;
    logic              out_regwrite;
    logic              out_memwrite;
    logic              out_uncondbr;
    logic              out_condbr;
    logic              out_cbz;
    logic              out_bl;
    logic              out_br;
    logic              out_setflags;
    logic              out_illegal;
    logic [2:0]        out_aluop;
    logic [4:0]        out_rn;
    logic [4:0]        out_rm;
    logic [4:0]        out_rd;
    logic [3:0]        out_cond;
    logic [DATA_W-1:0] out_imm;
    logic [PC_W-1:0]   out_br_offset;

    // Decoder view: consumes instructions, produces control bundles
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc,
        output out_reg2loc, out_alusrc, out_memtoreg, out_regwrite, out_memwrite,
        output out_uncondbr, out_condbr, out_cbz, out_bl, out_br, out_setflags, out_illegal,
        output out_aluop, out_rn, out_rm, out_rd, out_cond, out_imm, out_br_offset
    );

    // Surrounding pipeline view: supplies instructions, consumes bundles
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc,
        input  out_reg2loc, out_alusrc, out_memtoreg, out_regwrite, out_memwrite,
        input  out_uncondbr, out_condbr, out_cbz, out_bl, out_br, out_setflags, out_illegal,
        input  out_aluop, out_rn, out_rm, out_rd, out_cond, out_imm, out_br_offset
    );
endinterface

// File: rtl/pipelined_instruction_decoder.sv
// rtl/pipelined_instruction_decoder.sv - registered LEGv8 decode stage with load-use stall and flush
module pipelined_instruction_decoder #(
    parameter int DATA_W      = 64,
    parameter int PC_W        = 64,
    parameter int ZERO_REG    = 31,
    parameter int LINK_REG    = 30,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    pipelined_instruction_decoder_if.slave bus,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);
    localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              reg2loc;
        logic              alusrc;
        logic              memtoreg;
        logic              regwrite;
        logic              memwrite;
        logic              uncondbr;
        logic              condbr;
        logic              cbz;
        logic              bl;
        logic              br;
        logic              setflags;
        logic              illegal;
        logic [2:0]        aluop;
        logic [4:0]        rn;
        logic [4:0]        rm;
        logic [4:0]        rd;
        logic [3:0]        cond;
        logic [DATA_W-1:0] imm;
        logic [PC_W-1:0]   br_offset;
    } bundle_t;

    logic [31:0] instr;
    logic        is_addi, is_adds, is_subs, is_ldur, is_stur;
    logic        is_br, is_b, is_bl, is_bcond, is_cbz;
    logic        use_rn, use_rm;
    bundle_t     dec;
    bundle_t     q;
    logic        q_valid;
    logic        hazard;
    logic        accept;
    logic [STALL_CNT_W-1:0] stall_q;

    assign instr = bus.in_instr;

    // Opcode match and source-register usage of the incoming instruction
    always_comb begin
        is_addi  = (instr[31:22] == 10'b1001000100);
        is_adds  = (instr[31:21] == 11'b10101011000);
        is_subs  = (instr[31:21] == 11'b11101011000);
        is_ldur  = (instr[31:21] == 11'b11111000010);
        is_stur  = (instr[31:21] == 11'b11111000000);
        is_br    = (instr[31:21] == 11'b11010110000);
        is_b     = (instr[31:26] == 6'b000101);
        is_bl    = (instr[31:26] == 6'b100101);
        is_bcond = (instr[31:24] == 8'b01010100);
        is_cbz   = (instr[31:24] == 8'b10110100);
        use_rn   = is_addi | is_adds | is_subs | is_ldur | is_stur | is_br;
        use_rm   = is_adds | is_subs | is_stur | is_cbz;
    end

    // Control bundle for the incoming instruction
    always_comb begin
        dec          = '0;
        dec.pc       = bus.in_pc;
        dec.reg2loc  = is_adds | is_subs;
        dec.alusrc   = is_addi | is_ldur | is_stur;
        dec.memtoreg = is_ldur;
        dec.regwrite = is_addi | is_adds | is_subs | is_ldur | is_bl;
        dec.memwrite = is_stur;
        dec.uncondbr = is_b | is_bl;
        dec.condbr   = is_bcond;
        dec.cbz      = is_cbz;
        dec.bl       = is_bl;
        dec.br       = is_br;
        dec.setflags = is_adds | is_subs;
        dec.illegal  = !(is_addi | is_adds | is_subs | is_ldur | is_stur |
                         is_br | is_b | is_bl | is_bcond | is_cbz);
        if (is_subs) begin
            dec.aluop = ALU_SUB;
        end else if (is_addi | is_adds | is_ldur | is_stur) begin
            dec.aluop = ALU_ADD;
        end else begin
            dec.aluop = ALU_PASS;
        end
        dec.rn = instr[9:5];
        dec.rm = dec.reg2loc ? instr[20:16] : instr[4:0];
        dec.rd = is_bl ? LINK_IDX : instr[4:0];
        if (is_bcond) begin
            dec.cond = instr[3:0];
        end
        if (is_addi) begin
            dec.imm = {{(DATA_W-12){1'b0}}, instr[21:10]};
        end else if (is_ldur | is_stur) begin
            dec.imm = {{(DATA_W-9){instr[20]}}, instr[20:12]};
        end
        if (is_b | is_bl) begin
            dec.br_offset = {{(PC_W-28){instr[25]}}, instr[25:0], 2'b00};
        end else if (is_bcond | is_cbz) begin
            dec.br_offset = {{(PC_W-21){instr[23]}}, instr[23:5], 2'b00};
        end
    end

    // Load-use hazard: held load writes a register the incoming instruction reads
    always_comb begin
        hazard = q_valid & q.memtoreg & (q.rd != ZERO_IDX) & bus.in_valid &
                 ((use_rn & (dec.rn == q.rd)) | (use_rm & (dec.rm == q.rd)));
        bus.in_ready = !flush & !hazard & (!q_valid | bus.out_ready);
        accept       = bus.in_valid & bus.in_ready;
    end

    // Output register: flush kills, accept loads, consume drains, otherwise hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_valid <= 1'b0;
            q       <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (accept) begin
            q_valid <= 1'b1;
            q       <= dec;
        end else if (bus.out_ready) begin
            q_valid <= 1'b0;
        end
    end

    // Saturating count of load-use stall cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (hazard && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles      = stall_q;
    assign bus.out_valid     = q_valid;
    assign bus.out_pc        = q.pc;
    assign bus.out_reg2loc   = q.reg2loc;
    assign bus.out_alusrc    = q.alusrc;
    assign bus.out_memtoreg  = q.memtoreg;
    assign bus.out_regwrite  = q.regwrite;
    assign bus.out_memwrite  = q.memwrite;
    assign bus.out_uncondbr  = q.uncondbr;
    assign bus.out_condbr    = q.condbr;
    assign bus.out_cbz       = q.cbz;
    assign bus.out_bl        = q.bl;
    assign bus.out_br        = q.br;
    assign bus.out_setflags  = q.setflags;
    assign bus.out_illegal   = q.illegal;
    assign bus.out_aluop     = q.aluop;
    assign bus.out_rn        = q.rn;
    assign bus.out_rm        = q.rm;
    assign bus.out_rd        = q.rd;
    assign bus.out_cond      = q.cond;
    assign bus.out_imm       = q.imm;
    assign bus.out_br_offset = q.br_offset;
endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// tb/tb_pipelined_instruction_decoder.sv - directed self-checking bench for the decode stage
module tb_pipelined_instruction_decoder;
    localparam logic [31:0] ADDI_X1    = 32'h910007E1; // ADDI X1,X31,#1
    localparam logic [31:0] ADDI_ALT   = 32'h91000822; // ADDI X2,X1,#2
    localparam logic [31:0] LDUR_X2    = 32'hF85F8022; // LDUR X2,[X1,#-8]
    localparam logic [31:0] ADDS_X3    = 32'hAB040043; // ADDS X3,X2,X4
    localparam logic [31:0] LDUR_XZR   = 32'hF840003F; // LDUR X31,[X1,#0]
    localparam logic [31:0] ADDS_ZR    = 32'hAB1F03E5; // ADDS X5,X31,X31
    localparam logic [31:0] BCOND_M1   = 32'h54FFFFE1; // B.NE #-1 word
    localparam logic [31:0] BL_3       = 32'h94000003; // BL #3 words

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic [15:0] stall_cycles;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    pipelined_instruction_decoder_if #(.DATA_W(64), .PC_W(64)) dif ();

    pipelined_instruction_decoder #(
        .DATA_W(64), .PC_W(64), .ZERO_REG(31), .LINK_REG(30), .STALL_CNT_W(16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .bus          (dif),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] ins, input logic [63:0] pc);
        dif.in_valid = v;
        dif.in_instr = ins;
        dif.in_pc    = pc;
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        flush         = 1'b0;
        dif.out_ready = 1'b1;
        put(1'b0, 32'h0, 64'h0);
        tick();
        tick();
        check("rst_valid", dif.out_valid, 0);
        check("rst_pc", dif.out_pc, 0);
        check("rst_imm", dif.out_imm, 0);
        check("rst_illegal", dif.out_illegal, 0);
        check("rst_stall", stall_cycles, 0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", dif.in_ready, 1);

        // ADDI decode and one-cycle latency
        put(1'b1, ADDI_X1, 64'h100);
        check("addi_in_ready", dif.in_ready, 1);
        tick();
        put(1'b0, 32'h0, 64'h0);
        check("addi_valid", dif.out_valid, 1);
        check("addi_alusrc", dif.out_alusrc, 1);
        check("addi_regwrite", dif.out_regwrite, 1);
        check("addi_aluop", dif.out_aluop, 3'b010);
        check("addi_rn", dif.out_rn, 31);
        check("addi_rd", dif.out_rd, 1);
        check("addi_imm", dif.out_imm, 1);
        check("addi_pc", dif.out_pc, 64'h100);
        check("addi_reg2loc", dif.out_reg2loc, 0);
        tick();
        check("addi_drain", dif.out_valid, 0);

        // Load into XZR never stalls a reader of XZR
        put(1'b1, LDUR_XZR, 64'h104);
        tick();
        check("ldzr_memtoreg", dif.out_memtoreg, 1);
        check("ldzr_rd", dif.out_rd, 31);
        put(1'b1, ADDS_ZR, 64'h108);
        check("ldzr_in_ready", dif.in_ready, 1);
        tick();
        put(1'b0, 32'h0, 64'h0);
        check("ldzr_reader_valid", dif.out_valid, 1);
        check("ldzr_reader_pc", dif.out_pc, 64'h108);
        check("ldzr_stall", stall_cycles, 0);
        tick();

        // Load-use hazard costs exactly one bubble
        put(1'b1, LDUR_X2, 64'h200);
        tick();
        check("ldur_imm", dif.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_rd", dif.out_rd, 2);
        check("ldur_memtoreg", dif.out_memtoreg, 1);
        check("ldur_aluop", dif.out_aluop, 3'b010);
        put(1'b1, ADDS_X3, 64'h204);
        check("hz_in_ready", dif.in_ready, 0);
        tick();
        check("hz_bubble", dif.out_valid, 0);
        check("hz_stall", stall_cycles, 1);
        check("hz_in_ready_after", dif.in_ready, 1);
        tick();
        put(1'b0, 32'h0, 64'h0);
        check("adds_valid", dif.out_valid, 1);
        check("adds_pc", dif.out_pc, 64'h204);
        check("adds_reg2loc", dif.out_reg2loc, 1);
        check("adds_setflags", dif.out_setflags, 1);
        check("adds_rn", dif.out_rn, 2);
        check("adds_rm", dif.out_rm, 4);
        check("adds_rd", dif.out_rd, 3);
        tick();

        // Branches back to back
        put(1'b1, BCOND_M1, 64'h300);
        tick();
        put(1'b1, BL_3, 64'h304);
        check("bcond_condbr", dif.out_condbr, 1);
        check("bcond_cond", dif.out_cond, 1);
        check("bcond_offset", dif.out_br_offset, 64'hFFFF_FFFF_FFFF_FFFC);
        check("bcond_regwrite", dif.out_regwrite, 0);
        check("bl_in_ready", dif.in_ready, 1);
        tick();
        put(1'b0, 32'h0, 64'h0);
        check("bl_valid", dif.out_valid, 1);
        check("bl_flag", dif.out_bl, 1);
        check("bl_rd", dif.out_rd, 30);
        check("bl_regwrite", dif.out_regwrite, 1);
        check("bl_offset", dif.out_br_offset, 12);
        check("bl_cond", dif.out_cond, 0);
        tick();

        // Illegal encoding
        put(1'b1, 32'h0000_0000, 64'h400);
        tick();
        put(1'b0, 32'h0, 64'h0);
        check("ill_valid", dif.out_valid, 1);
        check("ill_flag", dif.out_illegal, 1);
        check("ill_regwrite", dif.out_regwrite, 0);
        check("ill_memwrite", dif.out_memwrite, 0);
        tick();

        // Hold under back-pressure, then flush drops the incoming instruction
        dif.out_ready = 1'b0;
        put(1'b1, ADDI_X1, 64'h500);
        tick();
        put(1'b1, ADDI_ALT, 64'h508);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", dif.out_valid, 1);
            check("hold_pc", dif.out_pc, 64'h500);
            check("hold_rd", dif.out_rd, 1);
            check("hold_in_ready", dif.in_ready, 0);
            tick();
        end
        flush = 1'b1;
        put(1'b1, ADDI_ALT, 64'h600);
        check("flush_in_ready", dif.in_ready, 0);
        tick();
        flush = 1'b0;
        dif.out_ready = 1'b1;
        put(1'b0, 32'h0, 64'h0);
        check("flush_valid", dif.out_valid, 0);
        tick();
        check("flush_dropped", dif.out_valid, 0);

        // Stall under back-pressure counts every cycle; async reset clears mid-stall
        dif.out_ready = 1'b0;
        put(1'b1, LDUR_X2, 64'h700);
        tick();
        put(1'b1, ADDS_X3, 64'h704);
        check("bp_hz_in_ready", dif.in_ready, 0);
        tick();
        tick();
        tick();
        check("bp_stall", stall_cycles, 4);
        check("bp_valid", dif.out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", dif.out_valid, 0);
        check("mid_rst_pc", dif.out_pc, 0);
        check("mid_rst_imm", dif.out_imm, 0);
        check("mid_rst_rd", dif.out_rd, 0);
        check("mid_rst_memtoreg", dif.out_memtoreg, 0);
        check("mid_rst_stall", stall_cycles, 0);
        put(1'b0, 32'h0, 64'h0);
        tick();
        reset_n = 1'b1;
        dif.out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", dif.in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pipelined_instruction_decoder.md
# pipelined_instruction_decoder

Registered, handshaked decode stage for the pipelined LEGv8 core, sitting between the fetch register (IF/ID) and the execute stage (ID/EX). It decodes ADDI, ADDS, SUBS, B, B.cond, BL, BR, CBZ, LDUR and STUR into a control bundle with register addresses and extended immediates. It detects load-use hazards against the instruction it holds, inserts bubbles for them, honours pipeline flushes, and counts stall cycles. Datapath widths are parametrised.

## Interface
- DATA_W, 64: width of extended immediate output.
- PC_W, 64: width of PC and branch offset.
- ZERO_REG, 31: register index that never causes a hazard (XZR).
- LINK_REG, 30: destination driven on out_rd for BL.
- STALL_CNT_W, 16: width of saturating stall counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of held and incoming instruction.
- in_valid  in  1  in_instr/in_pc valid.
- in_ready  out  1  decoder accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  address of in_instr.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  execute stage consumes bundle.
- out_pc  out  PC_W  registered in_pc.
- out_reg2loc, out_alusrc, out_memtoreg, out_regwrite, out_memwrite  out  1 each  datapath controls.
- out_uncondbr, out_condbr, out_cbz, out_bl, out_br, out_setflags, out_illegal  out  1 each  instruction class flags.
- out_aluop  out  3  000 pass-B, 010 add, 011 sub.
- out_rn, out_rm, out_rd  out  5 each  register addresses.
- out_cond  out  4  B.cond condition, instr[3:0]; 0 otherwise.
- out_imm  out  DATA_W  extended ALU/memory immediate.
- out_br_offset  out  PC_W  sign-extended word offset << 2.
- stall_cycles  out  STALL_CNT_W  saturating load-use stall count.

## Operation
- Opcodes: ADDI [31:22]=1001000100; ADDS [31:21]=10101011000; SUBS 11101011000; LDUR 11111000010; STUR 11111000000; BR 11010110000; B [31:26]=000101; BL 100101; B.cond [31:24]=01010100; CBZ 10110100. Anything else: out_illegal=1, all write enables and branch flags 0.
- Fields: out_rn=instr[9:5]; out_rm = reg2loc ? instr[20:16] : instr[4:0]; out_rd=instr[4:0], except BL: LINK_REG.
- reg2loc=1 for ADDS/SUBS only. alusrc=1 for ADDI/LDUR/STUR. regwrite for ADDI/ADDS/SUBS/LDUR/BL. memtoreg LDUR only. memwrite STUR only. setflags ADDS/SUBS. aluop 010 for ADDI/ADDS/LDUR/STUR, 011 SUBS, 000 otherwise.
- out_imm: ADDI zero-extends imm12 [21:10]; LDUR/STUR sign-extend imm9 [20:12]; 0 otherwise.
- out_br_offset: B/BL sign-extend imm26 [25:0]; B.cond/CBZ imm19 [23:5]; then <<2. 0 otherwise.
- Source use of incoming instr: Rn for ADDI/ADDS/SUBS/LDUR/STUR/BR; Rm field for ADDS/SUBS ([20:16]) and STUR/CBZ ([4:0]).
- hazard = out_valid & out_memtoreg & out_rd!=ZERO_REG & in_valid & (used source == out_rd).
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Transfer: in_valid & in_ready loads the output register with the decoded bundle, out_valid=1.
- Otherwise, out_ready=1 drains: out_valid=0 next cycle, which is a bubble under hazard. When out_valid & !out_ready, all outputs hold stable.
- flush: next edge out_valid=0; in_ready=0 that cycle; input dropped. Priority over all else.
- stall_cycles: +1 each cycle hazard=1; saturates at all-ones; cleared only by reset.

## Timing
- Latency 1 cycle from accepted input to out_valid. Throughput 1/cycle without hazards.
- Load-use costs exactly 1 bubble: cycle N hazard, load leaves; cycle N+1 dependent accepted.
- Hazard while out_ready=0: stall persists until load drains; counter counts every such cycle.
- in_ready is combinational from in_valid/in_instr, flush, out_ready and state; no comb path in_valid to out_*.
- Reset (asynchronous, any cycle, mid-stall included): out_valid=0, every out_* control/flag/field/imm/offset/pc=0, stall_cycles=0. in_ready=1 after release when flush=0.

## Test plan
- ADDI 0x910007E1 (X1=X31+1), out_ready=1 -> next cycle out_valid=1, alusrc=1, regwrite=1, aluop=010, rn=31, rd=1, out_imm=1.
- LDUR X2,[X1,#-8] then ADDS X3,X2,X4 back-to-back -> hazard cycle: in_ready=0, stall_cycles=1, one bubble; ADDS valid two cycles after LDUR, reg2loc=1, setflags=1.
- LDUR into X31 followed by a reader of X31 -> no stall, stall_cycles stays 0.
- B.cond imm19=-1, cond=0001 -> condbr=1, out_cond=1, out_br_offset=-4. BL imm26=3 -> rd=30, regwrite=1, offset=12.
- Held bundle with out_ready=0 for 5 cycles, then flush=1 -> outputs stable 5 cycles; out_valid=0 after flush edge; the incoming instruction is dropped.
- Instruction 0x00000000 -> out_illegal=1, regwrite=memwrite=0. Assert reset_n=0 mid-stall -> all outputs 0 immediately.
